// File: rtl/pci_initiator.sv
// pci_initiator: PCI bus master running the address phase, burst data phases and turnaround.
// Define PCI_INIT_MASTER_ABORT_EN to add the DEVSEL timeout / master-abort path.
module pci_initiator #(
  parameter int MAX_BURST = 8
`ifdef PCI_INIT_MASTER_ABORT_EN
  , parameter int DEVSEL_TIMEOUT = 5
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic        wr_pop,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic        frame,
  output logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  output logic        IRDY,
  input  logic        TRDY,
  input  logic        DEVSEL
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, LAST, ABORT, TURN} state_t;
  state_t      state_q;
  logic        frame_q, irdy_q, busy_q, done_q, abort_q, rd_valid_q, write_q;
  logic [31:0] addr_q, rd_data_q;
  logic [3:0]  cnt_q, len_d;
  logic        in_data, xfer, timeout, ad_oe;
  assign len_d   = (req_len == 4'd0) ? 4'd1 : (int'(req_len) > MAX_BURST) ? 4'(MAX_BURST) : req_len;
  assign in_data = (state_q == DATA) || (state_q == LAST);
  assign xfer    = in_data && !irdy_q && !TRDY && !DEVSEL;
  assign ad_oe   = (state_q == ADDR) || (in_data && write_q);
  assign AD      = ad_oe ? ((state_q == ADDR) ? addr_q : wr_data) : 'z;
  assign CBE     = (state_q == ADDR) ? {3'b011, write_q} : in_data ? (write_q ? wr_be : 4'b0000) : 4'b1111;
  assign wr_pop  = xfer && write_q;
  assign frame    = frame_q;
  assign IRDY     = irdy_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign abort    = abort_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`ifdef PCI_INIT_MASTER_ABORT_EN
  // Counts clocks since the address phase; saturates so a long wait cannot wrap.
  logic [7:0] to_q;
  assign timeout = in_data && DEVSEL && (to_q >= 8'(DEVSEL_TIMEOUT));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) to_q <= '0;
    else if (state_q == IDLE) to_q <= '0;
    else if (to_q != 8'hff) to_q <= to_q + 8'd1;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frame_q    <= 1'b1;
      irdy_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      rd_valid_q <= xfer && !write_q;
      if (xfer && !write_q) rd_data_q <= AD;
      case (state_q)
        IDLE: if (req) begin
          state_q <= ADDR;
          frame_q <= 1'b0;
          busy_q  <= 1'b1;
          write_q <= req_write;
          addr_q  <= req_addr;
          cnt_q   <= len_d;
        end
        ADDR: begin
          state_q <= (cnt_q == 4'd1) ? LAST : DATA;
          frame_q <= (cnt_q == 4'd1);
          irdy_q  <= 1'b0;
        end
        DATA: if (timeout) begin
          state_q <= ABORT;
          frame_q <= 1'b1;
        end else if (xfer) begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd2) begin
            state_q <= LAST;
            frame_q <= 1'b1;
          end
        end
        LAST: if (timeout) state_q <= ABORT;
        else if (xfer) begin
          state_q <= TURN;
          irdy_q  <= 1'b1;
          done_q  <= 1'b1;
        end
        ABORT: begin
          state_q <= TURN;
          irdy_q  <= 1'b1;
          abort_q <= 1'b1;
        end
        TURN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
